// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing diff = a - b - bin, one bit per clock, LSB first
// Ports: clk/rst (sync, active-high); in_valid/in_ready accept a, b, bin;
//        out_valid/out_ready present diff, bout (and ovf) after WIDTH SHIFT cycles.
// Option: define SERIAL_SUB_OVF_EN to add the ovf port (signed two's-complement overflow).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bout_q, bout_d, d, br_next;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  assign d = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff = diff_q;
  assign bout = bout_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    br_d = br_q;
    cnt_d = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d = ovf_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        a_d = a;
        b_d = b;
        br_d = bin;
        cnt_d = '0;
      end
      SHIFT: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        br_d = br_next;
        diff_d = {d, diff_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          bout_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
          // a_q[0]/b_q[0] are the operand MSBs on this last step
          ovf_d = (a_q[0] ^ b_q[0]) & (d ^ a_q[0]);
`endif
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      br_q <= 1'b0;
      cnt_q <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      br_q <= br_d;
      cnt_q <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard testbench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic bin = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] diff;
  logic bout;
  logic ovf;
  int tests_run = 0;
  int failed = 0;
  typedef struct {
    logic [7:0] d;
    logic bo;
    logic ov;
  } exp_t;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    exp_t e;
    full = {1'b0, x} - {1'b0, y} - {8'd0, c};
    e.d = full[7:0];
    e.bo = full[8];
    e.ov = (x[7] ^ y[7]) & (e.d[7] ^ x[7]);
    return e;
  endfunction

  // Performs one transaction; hold = backpressure cycles in DONE, keep = leave in_valid high afterwards.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c, input int hold, input bit keep);
    int n;
    exp_t e;
    logic [7:0] held_d;
    logic held_b;
    tests_run++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL in_ready_before_accept: got %b want 1", in_ready);
    end
    a = x; b = y; bin = c; in_valid = 1'b1;
    sb.push_back(model(x, y, c));
    @(posedge clk);
    @(negedge clk);
    in_valid = keep;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!out_valid && in_ready !== 1'b0) begin
        tests_run++;
        failed++;
        $display("FAIL in_ready_in_shift: got %b want 0", in_ready);
      end
    end
    tests_run++;
    if (n !== 8) begin
      failed++;
      $display("FAIL latency: got %0d cycles want 8", n);
    end
    if (sb.size() == 0) begin
      tests_run++;
      failed++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      tests_run++;
      if (diff !== e.d || bout !== e.bo) begin
        failed++;
        $display("FAIL result a=%h b=%h bin=%b: got diff=%h bout=%b want diff=%h bout=%b", x, y, c, diff, bout, e.d, e.bo);
      end
`ifdef SERIAL_SUB_OVF_EN
      tests_run++;
      if (ovf !== e.ov) begin
        failed++;
        $display("FAIL ovf a=%h b=%h: got %b want %b", x, y, ovf, e.ov);
      end
`endif
    end
    held_d = diff;
    held_b = bout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (diff !== held_d || bout !== held_b || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failed++;
        $display("FAIL backpressure cycle %0d: got diff=%h bout=%b ov=%b ir=%b want diff=%h bout=%b ov=1 ir=0", i, diff, bout, out_valid, in_ready, held_d, held_b);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== held_d || bout !== held_b) begin
      failed++;
      $display("FAIL release_to_idle: got ir=%b ov=%b diff=%h bout=%b want ir=1 ov=0 diff=%h bout=%b", in_ready, out_valid, diff, bout, held_d, held_b);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: got ir=%b ov=%b diff=%h bout=%b ovf=%b want 1 0 00 0 0", in_ready, out_valid, diff, bout, ovf);
    end
  endtask

  task automatic test_vectors;
    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) run_op(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0);
  endtask

  task automatic test_truth_table;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op({7'd0, v[2]}, {7'd0, v[1]}, v[0], 0, 1'b0);
    end
  endtask

  task automatic test_backpressure;
    run_op(8'h3C, 8'h5A, 1'b1, 20, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op(8'h12, 8'h34, 1'b0, 0, 1'b1);
    run_op(8'hA5, 8'h5A, 1'b1, 0, 1'b1);
    run_op(8'h01, 8'h02, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_shift;
    a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_shift: got ir=%b ov=%b diff=%h bout=%b want 1 0 00 0", in_ready, out_valid, diff, bout);
    end
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        failed++;
        $display("FAIL aborted_op_result: got out_valid=%b want 0", out_valid);
      end
    end
    run_op(8'h10, 8'h01, 1'b0, 0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_vectors();
    test_truth_table();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand set a/b/bin present.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  minuend.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: out_valid  output  1  result present.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port: bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).
REQ-013 SHALL have port, only when SERIAL_SUB_OVF_EN is defined: ovf  output  1  signed two's-complement overflow.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL, on a rising edge in IDLE with in_valid=1, capture a, b, bin into internal shift/borrow registers, clear the bit counter, and enter SHIFT.
REQ-017 SHALL, in SHIFT, process exactly one bit per cycle, LSB first, using full-subtractor logic: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-018 SHALL shift each produced d into the diff register from the MSB end so that after WIDTH SHIFT cycles diff holds the complete result in natural bit order.
REQ-019 SHALL count SHIFT cycles with a counter of ceil(log2(WIDTH+1)) bits; on the edge that processes bit WIDTH-1, enter DONE.
REQ-020 SHALL assert out_valid exactly WIDTH cycles after the accepting edge; total accept-to-result latency = WIDTH clock cycles.
REQ-021 SHALL hold diff, bout (and ovf) stable while in DONE with out_ready=0 (backpressure, unlimited duration).
REQ-022 SHALL, on a rising edge in DONE with out_ready=1, return to IDLE; no new operand accepted on that same edge (back-to-back throughput = one result per WIDTH+2 cycles).
REQ-023 SHALL ignore in_valid in SHIFT and DONE; a, b, bin may change freely after acceptance without affecting the result.
REQ-024 SHALL leave diff/bout holding the last result in IDLE (not cleared) until the next acceptance.
REQ-025 SHALL never enter an undefined state; any unencoded state value SHALL return to IDLE on the next edge.

Reset
REQ-026 SHALL, when rst=1 on a rising edge, force IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, counter=0, regardless of current state (including mid-SHIFT or DONE).
REQ-027 SHALL give rst priority over in_valid and out_ready on the same edge; an operation aborted by reset SHALL produce no result.

Configuration
REQ-028 SHALL, when macro SERIAL_SUB_OVF_EN is defined, provide port ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]) evaluated at the MSB step (bin treated as part of subtrahend), registered and valid with out_valid.
REQ-029 SHALL, when SERIAL_SUB_OVF_EN is undefined, omit port ovf and all related logic; all other behaviour identical.

Verification (WIDTH=8)
REQ-030 SHALL cover: a=0x05, b=0x03, bin=0 -> out_valid 8 cycles after accept, diff=0x02, bout=0, ovf=0.
REQ-031 SHALL cover: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-032 SHALL cover (SERIAL_SUB_OVF_EN defined): a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-033 SHALL cover backpressure: out_ready=0 for 20 cycles in DONE -> diff/bout unchanged, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 SHALL cover reset at SHIFT bit 4 of a=0xAA, b=0x55 -> next cycle IDLE, out_valid=0, diff=0, bout=0; following op a=0x10, b=0x01 -> diff=0x0F, bout=0.
REQ-035 SHALL cover all 8 {a[0], b[0], bin} combinations with WIDTH=8, upper bits zero, matching the full-subtractor truth table in diff[0] and bout.
